// File: rtl/oled_page_streamer.sv
// oled_page_streamer: framebuffer-to-SSD1306 refresh engine.
// Reads the monochrome framebuffer one 8-pixel page column at a time. Each
// column byte is bit-reversed into SSD1306 page order and streamed out over a
// valid/ready byte link.
// Optional feature macro: OLED_PAGE_CMD_EN. When it is defined, each page is
// preceded by the 3 addressing command bytes 0xB0|page, 0x00, 0x10.
//
// Handshake: a byte transfers on a rising edge where tx_valid && tx_ready.
// Once tx_valid rises it stays high, and tx_data/tx_dc stay frozen, until
// that edge.
module oled_page_streamer #(
  parameter int H_PIXELS = 128,
  parameter int V_PIXELS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       fb_re,
  output logic [7:0] fb_xpos,
  output logic [7:0] fb_ypos,
  output logic       fb_rmode,
  input  logic [7:0] fb_dout,
  output logic [7:0] tx_data,
  output logic       tx_dc,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_RD   = 3'd2,
    S_LAT  = 3'd3,
    S_SEND = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [7:0] LAST_COL  = 8'(H_PIXELS - 1);
  localparam logic [2:0] LAST_PAGE = 3'(V_PIXELS / 8 - 1);

  state_t     state;
  logic [7:0] col;
  logic [2:0] page;
  logic       hs;
`ifdef OLED_PAGE_CMD_EN
  logic [1:0] cmd_idx;
`endif

  // Framebuffer bit7 is the top row. SSD1306 wants bit0 at the top.
  function automatic logic [7:0] bit_rev(input logic [7:0] d);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = d[7-k];
    return r;
  endfunction

  assign hs        = tx_valid && tx_ready;
  assign fb_rmode  = 1'b1;
  assign dbg_state = state;

  // Frame sequencer: page/column walk, read strobe and output byte register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      col      <= 8'd0;
      page     <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fb_re    <= 1'b0;
      fb_xpos  <= 8'd0;
      fb_ypos  <= 8'd0;
      tx_data  <= 8'd0;
      tx_dc    <= 1'b0;
      tx_valid <= 1'b0;
`ifdef OLED_PAGE_CMD_EN
      cmd_idx  <= 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            col  <= 8'd0;
            page <= 3'd0;
`ifdef OLED_PAGE_CMD_EN
            state    <= S_CMD;
            tx_data  <= 8'hB0;
            tx_dc    <= 1'b0;
            tx_valid <= 1'b1;
            cmd_idx  <= 2'd0;
`else
            state   <= S_RD;
            fb_re   <= 1'b1;
            fb_xpos <= 8'd0;
            fb_ypos <= 8'd0;
`endif
          end
        end
`ifdef OLED_PAGE_CMD_EN
        S_CMD: begin
          // The page address byte is loaded on entry. The column-address pair
          // follows it on successive handshakes.
          if (hs) begin
            case (cmd_idx)
              2'd0: begin
                tx_data <= 8'h00;
                cmd_idx <= 2'd1;
              end
              2'd1: begin
                tx_data <= 8'h10;
                cmd_idx <= 2'd2;
              end
              default: begin
                tx_valid <= 1'b0;
                state    <= S_RD;
                fb_re    <= 1'b1;
                fb_xpos  <= col;
                fb_ypos  <= {2'b00, page, 3'b000};
              end
            endcase
          end
        end
`endif
        S_RD: begin
          fb_re <= 1'b0;
          state <= S_LAT;
        end
        S_LAT: begin
          tx_data  <= bit_rev(fb_dout);
          tx_dc    <= 1'b1;
          tx_valid <= 1'b1;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (hs) begin
            tx_valid <= 1'b0;
            if (col != LAST_COL) begin
              col     <= col + 8'd1;
              state   <= S_RD;
              fb_re   <= 1'b1;
              fb_xpos <= col + 8'd1;
              fb_ypos <= {2'b00, page, 3'b000};
            end else if (page != LAST_PAGE) begin
              col  <= 8'd0;
              page <= page + 3'd1;
`ifdef OLED_PAGE_CMD_EN
              state    <= S_CMD;
              tx_data  <= {5'b10110, page + 3'd1};
              tx_dc    <= 1'b0;
              tx_valid <= 1'b1;
              cmd_idx  <= 2'd0;
`else
              state   <= S_RD;
              fb_re   <= 1'b1;
              fb_xpos <= 8'd0;
              fb_ypos <= {2'b00, page + 3'd1, 3'b000};
`endif
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oled_page_streamer.sv
// tb_oled_page_streamer: randomized self-checking bench for oled_page_streamer.
// Follows whichever build of OLED_PAGE_CMD_EN the design is compiled with.
`timescale 1ns/1ps
module tb_oled_page_streamer;

`ifdef OLED_PAGE_CMD_EN
  localparam bit         CMD_EN   = 1'b1;
  localparam int         N_BYTES  = 1048;
  localparam int         BUSY_CYC = 3096;
  localparam logic [8:0] FIRST0   = 9'h0B0;
  localparam logic [8:0] FIRST1   = 9'h000;
  localparam logic [8:0] FIRST2   = 9'h010;
  localparam logic [8:0] FIRST3   = 9'h101;
  localparam int         P1_IDX   = 131;
  localparam logic [8:0] P1_BYTE  = 9'h0B1;
`else
  localparam bit         CMD_EN   = 1'b0;
  localparam int         N_BYTES  = 1024;
  localparam int         BUSY_CYC = 3072;
  localparam logic [8:0] FIRST0   = 9'h101;
  localparam logic [8:0] FIRST1   = 9'h100;
  localparam logic [8:0] FIRST2   = 9'h100;
  localparam logic [8:0] FIRST3   = 9'h100;
  localparam int         P1_IDX   = 128;
  localparam logic [8:0] P1_BYTE  = 9'h100;
`endif
  localparam int N_DATA = 1024;
  localparam int BUDGET = 20000;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       fb_re;
  logic [7:0] fb_xpos;
  logic [7:0] fb_ypos;
  logic       fb_rmode;
  logic [7:0] fb_dout = 8'd0;
  logic [7:0] tx_data;
  logic       tx_dc;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] dbg_state;

  oled_page_streamer #(.H_PIXELS(128), .V_PIXELS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .fb_re(fb_re), .fb_xpos(fb_xpos), .fb_ypos(fb_ypos), .fb_rmode(fb_rmode),
    .fb_dout(fb_dout), .tx_data(tx_data), .tx_dc(tx_dc), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .dbg_state(dbg_state)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel image, indexed as pix[row][column].
  bit pix [0:63][0:127];

  int tests = 0;
  int fails = 0;
  int byte_cnt, rd_cnt, busy_cnt, done_cnt;
  int first_rd_x, first_rd_y, last_rd_x, last_rd_y;
  int ready_mode = 0;
  bit mon_off = 1'b1;
  bit prev_stall = 1'b0;
  logic [8:0] prev_byte;
  logic [8:0] exp_q[$];
  logic [8:0] act_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Framebuffer read port: column read, bit7 = row y, 1-cycle latency.
  function automatic logic [7:0] col_byte(input int x, input int y);
    logic [7:0] r;
    r = 8'd0;
    if (x < 128 && y < 57)
      for (int k = 0; k < 8; k++) r[7-k] = pix[y+k][x];
    return r;
  endfunction

  always @(posedge clk) begin
    if (fb_re) fb_dout <= col_byte(int'(fb_xpos), int'(fb_ypos));
  end

  // Expected byte stream, built straight from the image: bit k = row page*8+k.
  task automatic build_exp();
    logic [7:0] b;
    exp_q.delete();
    for (int p = 0; p < 8; p++) begin
      if (CMD_EN) begin
        exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h010);
      end
      for (int c = 0; c < 128; c++) begin
        for (int k = 0; k < 8; k++) b[k] = pix[p*8+k][c];
        exp_q.push_back({1'b1, b});
      end
    end
  endtask

  task automatic clear_pix();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 128; c++) pix[r][c] = 1'b0;
  endtask

  task automatic random_pix();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 128; c++) pix[r][c] = 1'($urandom_range(0, 1));
  endtask

  // Ready driver plus per-cycle compare against the expected queue.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      tx_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mon_off) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_byte", 32'({tx_dc, tx_data}), 32'(prev_byte));
        end
        if (tx_valid && tx_ready) begin
          act_q.push_back({tx_dc, tx_data});
          byte_cnt++;
          if (exp_q.size() == 0) check("extra_byte", 32'(exp_q.size()), 32'd1);
          else check("tx_byte", 32'({tx_dc, tx_data}), 32'(exp_q.pop_front()));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_byte  = {tx_dc, tx_data};
        if (fb_re) begin
          check("rd_xpos", 32'(fb_xpos), 32'(rd_cnt % 128));
          check("rd_ypos", 32'(fb_ypos), 32'((rd_cnt / 128) * 8));
          check("rd_rmode", 32'(fb_rmode), 32'd1);
          check("rd_while_pending", 32'(tx_valid), 32'd0);
          if (rd_cnt == 0) begin
            first_rd_x = int'(fb_xpos);
            first_rd_y = int'(fb_ypos);
          end
          last_rd_x = int'(fb_xpos);
          last_rd_y = int'(fb_ypos);
          rd_cnt++;
        end
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  // Driver tasks.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic begin_frame(input int mode);
    build_exp();
    act_q.delete();
    byte_cnt = 0;
    rd_cnt = 0;
    busy_cnt = 0;
    done_cnt = 0;
    ready_mode = mode;
    pulse_start();
    check("busy_rise", 32'(busy), 32'd1);
    check("first_cycle", 32'({tx_valid, fb_re}), CMD_EN ? 32'h2 : 32'h1);
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < BUDGET && byte_cnt < n; i++) @(negedge clk);
    check("reach_byte", 32'(byte_cnt >= n), 32'd1);
  endtask

  task automatic end_frame(input bit exact_busy);
    for (int i = 0; i < BUDGET && done_cnt == 0; i++) @(negedge clk);
    check("done_seen", 32'(done_cnt > 0), 32'd1);
    repeat (4) @(negedge clk);
    check("done_once", 32'(done_cnt), 32'd1);
    check("byte_total", 32'(byte_cnt), 32'(N_BYTES));
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    check("read_total", 32'(rd_cnt), 32'(N_DATA));
    check("busy_after", 32'(busy), 32'd0);
    if (exact_busy) check("busy_cycles", 32'(busy_cnt), 32'(BUSY_CYC));
    else check("busy_min", 32'(busy_cnt >= BUSY_CYC), 32'd1);
  endtask

  // Main sequence and final report.
  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fb_re", 32'(fb_re), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_tx_dc", 32'(tx_dc), 32'd0);
    check("rst_xpos", 32'(fb_xpos), 32'd0);
    check("rst_ypos", 32'(fb_ypos), 32'd0);
    check("rst_rmode", 32'(fb_rmode), 32'd1);
    rst = 1'b0;
    prev_stall = 1'b0;
    mon_off = 1'b0;

    // Single pixel (0,0), ready held high.
    clear_pix();
    pix[0][0] = 1'b1;
    begin_frame(0);
    end_frame(1'b1);
    check("lit_byte0", 32'(act_q[0]), 32'(FIRST0));
    check("lit_byte1", 32'(act_q[1]), 32'(FIRST1));
    check("lit_byte2", 32'(act_q[2]), 32'(FIRST2));
    check("lit_byte3", 32'(act_q[3]), 32'(FIRST3));
    check("lit_page1", 32'(act_q[P1_IDX]), 32'(P1_BYTE));

    // Random image under random backpressure.
    random_pix();
    begin_frame(1);
    end_frame(1'b0);

    // A start pulse mid-frame must be ignored.
    random_pix();
    begin_frame(1);
    wait_bytes(100);
    pulse_start();
    end_frame(1'b0);

    // Reset at byte 500 aborts the frame; the next frame restarts at page 0.
    clear_pix();
    pix[0][0] = 1'b1;
    begin_frame(0);
    wait_bytes(500);
    @(negedge clk);
    mon_off = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_fb_re", 32'(fb_re), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    mon_off = 1'b0;
    begin_frame(0);
    end_frame(1'b1);
    check("restart_byte0", 32'(act_q[0]), 32'(FIRST0));
    check("restart_rd_x", 32'(first_rd_x), 32'd0);
    check("restart_rd_y", 32'(first_rd_y), 32'd0);

    // Single pixel (127,63): lands in bit7 of the very last byte.
    clear_pix();
    pix[63][127] = 1'b1;
    begin_frame(0);
    end_frame(1'b1);
    check("last_byte", 32'(act_q[act_q.size()-1]), 32'h180);
    check("last_rd_x", 32'(last_rd_x), 32'd127);
    check("last_rd_y", 32'(last_rd_y), 32'd56);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oled_page_streamer.md
# oled_page_streamer

Framebuffer-to-display refresh engine for the 128x64 monochrome OLED path. On a `start` pulse it walks the monochrome framebuffer's read port in column mode, one 8-pixel page column at a time. It converts each column byte into SSD1306 page-format byte order and streams the bytes, with optional per-page addressing commands, to the serial display transmitter over a valid/ready byte interface. It is the consumer (read side) of the framebuffer; the pixel-drawing logic is the producer (write side).

## Interface
- `H_PIXELS`, 128, display width in pixels (columns per page)
- `V_PIXELS`, 64, display height in pixels; page count = `V_PIXELS/8`
- `clk`  in  1  module clock
- `rst`  in  1  reset; synchronous, active-high, sampled on `clk` rising edge
- `start`  in  1  begin one full-frame refresh; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted until frame end
- `done`  out  1  one-cycle pulse after the final byte handshake
- `fb_re`  out  1  framebuffer read enable, one-cycle pulse per data byte
- `fb_xpos`  out  8  read column, 0..`H_PIXELS`-1
- `fb_ypos`  out  8  read row = page*8
- `fb_rmode`  out  1  constant 1 (column read)
- `fb_dout`  in  8  framebuffer read data, valid the cycle after `fb_re`; bit7 = row `fb_ypos`, bit0 = row `fb_ypos`+7
- `tx_data`  out  8  byte to display transmitter
- `tx_dc`  out  1  0 = command byte, 1 = display data byte
- `tx_valid`  out  1  `tx_data`/`tx_dc` valid
- `tx_ready`  in  1  transmitter accepts the byte when `tx_valid && tx_ready` at a rising edge

## Operation
- States: IDLE, CMD, RD, LAT, SEND, DONE.
- IDLE: `start`=1 -> page=0, col=0, next state CMD (macro on) or RD (macro off). `busy`=1 from the next cycle.
- CMD: emits 3 command bytes in order: `0xB0|page`, `0x00`, `0x10`, each with `tx_dc`=0. Each byte is held until its handshake. After the third byte -> RD.
- RD: `fb_re`=1 for exactly one cycle, with `fb_xpos`=col, `fb_ypos`=page*8 and `fb_rmode`=1. Next state LAT.
- LAT: captures `fb_dout` bit-reversed into `tx_data`, so that `tx_data[k]` = `fb_dout[7-k]` (bit0 = top pixel of the page). Sets `tx_dc`=1 and `tx_valid`=1. Next state SEND.
- SEND: holds `tx_valid`, `tx_data` and `tx_dc` stable until the handshake. On handshake:
  - if col < `H_PIXELS`-1: col+1 -> RD;
  - else if page < `V_PIXELS/8`-1: col=0, page+1 -> CMD (macro on) or RD (macro off);
  - else -> DONE.
- DONE: `done`=1 and `busy`=0 for one cycle -> IDLE.
- `start` while busy: ignored, no queuing.
- `tx_valid` never drops before its handshake. `tx_data` and `tx_dc` never change while `tx_valid && !tx_ready`.
- Counters: col is 8 bits and page is 3 bits. Both wrap only through the explicit transitions above; no arithmetic overflow is reachable.

## Timing
- Reset value of every output is 0, except `fb_rmode`=1. Reset returns the FSM to IDLE.
- `rst` mid-frame aborts the frame: `tx_valid`, `fb_re`, `busy` and `done` are all 0 in the cycle after the reset edge. No `done` pulse is issued. The next `start` restarts at page 0.
- Framebuffer read latency is fixed at 1 cycle; no read is issued while a byte is pending.
- With `tx_ready` tied high:
  - a data byte takes 3 cycles (RD, LAT, SEND);
  - a command byte takes 1 cycle.
- Frame duration with `tx_ready` tied high:
  - macro on: 8*(3+128*3) = 3096 busy cycles;
  - macro off: 3072 busy cycles.
  - `done` fires in the cycle after the last busy cycle.
- The first command byte (macro on) or the first `fb_re` (macro off) occurs in the first busy cycle.

## Configuration
- `OLED_PAGE_CMD_EN` defined: each page is preceded by the 3 addressing command bytes (1048 bytes per frame).
- `OLED_PAGE_CMD_EN` undefined: the CMD state is removed and only 1024 data bytes are sent, with `tx_dc` always 1. The display must already be configured for horizontal addressing with the full window.

## Test plan
- Reset: assert `rst` 2 cycles -> all outputs 0 except `fb_rmode`=1; `busy`=0.
- Framebuffer model with only pixel (0,0) set, macro on, `tx_ready`=1, pulse `start` -> bytes B0,00,10,01, then 127x00, B1,00,10, ...; 1048 bytes total; `done` pulses 3096 cycles after `busy` rises.
- Same frame with random `tx_ready` backpressure (about 50%) -> identical byte sequence; `tx_data` and `tx_dc` stable whenever `tx_valid && !tx_ready`; exactly one `fb_re` per data byte.
- `start` re-pulsed at byte 100 -> ignored; the frame completes with exactly one `done` and 1048 bytes.
- `rst` asserted at byte 500 -> `tx_valid`=0 and `busy`=0 the next cycle; a new `start` yields first byte 0xB0 with `fb_ypos`=0 and `fb_xpos`=0.
- Macro off, only pixel (127,63) set -> 1024 bytes, `tx_dc` always 1, last byte 0x80 with `fb_xpos`=127 and `fb_ypos`=56 on its read; `done` after 3072 busy cycles.
